// File: rtl/sync_fifo_stat.sv
// Synchronous single-clock FIFO with occupancy flags, accept strobes, flush,
// sticky overflow/underflow errors and a high-watermark statistic.
module sync_fifo_stat #(
    parameter int unsigned FIFO_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned AF_THRESH  = FIFO_DEPTH - 2,
    parameter int unsigned AE_THRESH  = 1
) (
    input  logic                               i_clk,
    input  logic                               i_rstn,
    input  logic                               push,
    input  logic [FIFO_WIDTH-1:0]              push_data,
    input  logic                               pop,
    output logic [FIFO_WIDTH-1:0]              pop_data,
    output logic                               push_ok,
    output logic                               pop_ok,
    input  logic                               flush,
    input  logic                               stat_clr,
    output logic                               fifo_full,
    output logic                               fifo_empty,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    max_count,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr_next;
    logic [PW-1:0]         wr_ptr_next;
    logic [CW-1:0]         count_next;
    logic [CW-1:0]         max_next;
    logic                  ovf_set;
    logic                  udf_set;

    // Status flags decode straight from the registered occupancy
    assign fifo_full    = (count == CW'(FIFO_DEPTH));
    assign fifo_empty   = (count == '0);
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

    // A pop frees a slot, so a push into a full FIFO is accepted alongside it
    assign pop_ok  = pop & ~fifo_empty & ~flush;
    assign push_ok = push & (~fifo_full | pop_ok) & ~flush;

    assign ovf_set = push & ~push_ok & ~flush;
    assign udf_set = pop & ~pop_ok & ~flush;

    assign pop_data = fifo_empty ? '0 : mem[rd_ptr];

    always_comb begin
        rd_ptr_next = rd_ptr;
        wr_ptr_next = wr_ptr;
        count_next  = count;
        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (pop_ok) begin
                rd_ptr_next = (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            if (push_ok) begin
                wr_ptr_next = (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            count_next = count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Watermark restarts from the post-edge occupancy on stat_clr
    always_comb begin
        max_next = max_count;
        if (stat_clr) begin
            max_next = count_next;
        end else if (count_next > max_count) begin
            max_next = count_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            max_count <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_ptr    <= rd_ptr_next;
            wr_ptr    <= wr_ptr_next;
            count     <= count_next;
            max_count <= max_next;
            overflow  <= ovf_set | (overflow & ~stat_clr & ~flush);
            underflow <= udf_set | (underflow & ~stat_clr & ~flush);
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: tb/tb_sync_fifo_stat.sv
// Table-driven bench for sync_fifo_stat (W=16, D=6, AF=5, AE=1) with a data
// scoreboard fed from the expected accepts.
module tb_sync_fifo_stat;

    localparam int unsigned W  = 16;
    localparam int unsigned D  = 6;
    localparam int unsigned CW = 3;

    logic          i_clk = 1'b0;
    logic          i_rstn = 1'b0;
    logic          push = 1'b0;
    logic [W-1:0]  push_data = '0;
    logic          pop = 1'b0;
    logic [W-1:0]  pop_data;
    logic          push_ok;
    logic          pop_ok;
    logic          flush = 1'b0;
    logic          stat_clr = 1'b0;
    logic          fifo_full;
    logic          fifo_empty;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] count;
    logic [CW-1:0] max_count;
    logic          overflow;
    logic          underflow;

    sync_fifo_stat #(
        .FIFO_WIDTH(W),
        .FIFO_DEPTH(D),
        .AF_THRESH (5),
        .AE_THRESH (1)
    ) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .push        (push),
        .push_data   (push_data),
        .pop         (pop),
        .pop_data    (pop_data),
        .push_ok     (push_ok),
        .pop_ok      (pop_ok),
        .flush       (flush),
        .stat_clr    (stat_clr),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .max_count   (max_count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 i_clk = ~i_clk;

    // Inputs for one cycle plus the state expected during that cycle (before its edge)
    typedef struct {
        logic        push;
        logic [15:0] data;
        logic        pop;
        logic        flush;
        logic        stat_clr;
        logic        e_pok;
        logic        e_qok;
        int          e_cnt;
        logic        e_ovf;
        logic        e_udf;
        int          e_max;
    } vec_t;

    vec_t        vecs[$];
    vec_t        vecs2[$];
    logic [15:0] sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic vec_t mk(input logic ps, input logic [15:0] d, input logic pp,
                                input logic fl, input logic sc, input logic pok,
                                input logic qok, input int cnt, input logic ovf,
                                input logic udf, input int mx);
        vec_t v;
        v.push = ps; v.data = d; v.pop = pp; v.flush = fl; v.stat_clr = sc;
        v.e_pok = pok; v.e_qok = qok; v.e_cnt = cnt; v.e_ovf = ovf;
        v.e_udf = udf; v.e_max = mx;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input int cnt);
        chk({tag, " count"},        32'(count),        32'(cnt));
        chk({tag, " fifo_full"},    32'(fifo_full),    32'(cnt == D));
        chk({tag, " fifo_empty"},   32'(fifo_empty),   32'(cnt == 0));
        chk({tag, " almost_full"},  32'(almost_full),  32'(cnt >= 5));
        chk({tag, " almost_empty"}, 32'(almost_empty), 32'(cnt <= 1));
    endtask

    task automatic apply(input vec_t v, input string tag);
        logic [15:0] exp_data;
        @(negedge i_clk);
        push = v.push; push_data = v.data; pop = v.pop;
        flush = v.flush; stat_clr = v.stat_clr;
        #1;
        exp_data = (sb.size() == 0) ? 16'h0000 : sb[0];
        chk({tag, " pop_data"},  32'(pop_data),  32'(exp_data));
        chk({tag, " push_ok"},   32'(push_ok),   32'(v.e_pok));
        chk({tag, " pop_ok"},    32'(pop_ok),    32'(v.e_qok));
        chk({tag, " overflow"},  32'(overflow),  32'(v.e_ovf));
        chk({tag, " underflow"}, 32'(underflow), 32'(v.e_udf));
        chk({tag, " max_count"}, 32'(max_count), 32'(v.e_max));
        chk_flags(tag, v.e_cnt);
        // Head leaves before the new word joins, so a full push+pop stays ordered
        if (v.flush) begin
            sb.delete();
        end else begin
            if (v.e_qok && sb.size() > 0) void'(sb.pop_front());
            if (v.e_pok) sb.push_back(v.data);
        end
    endtask

    initial begin
        // Fill 1..6, pop 3, push 7..9 across the pointer wrap
        vecs.push_back(mk(1, 16'h0001, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 16'h0002, 0, 0, 0, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 16'h0003, 0, 0, 0, 1, 0, 2, 0, 0, 2));
        vecs.push_back(mk(1, 16'h0004, 0, 0, 0, 1, 0, 3, 0, 0, 3));
        vecs.push_back(mk(1, 16'h0005, 0, 0, 0, 1, 0, 4, 0, 0, 4));
        vecs.push_back(mk(1, 16'h0006, 0, 0, 0, 1, 0, 5, 0, 0, 5));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 1, 6, 0, 0, 6));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 1, 5, 0, 0, 6));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 1, 4, 0, 0, 6));
        vecs.push_back(mk(1, 16'h0007, 0, 0, 0, 1, 0, 3, 0, 0, 6));
        vecs.push_back(mk(1, 16'h0008, 0, 0, 0, 1, 0, 4, 0, 0, 6));
        vecs.push_back(mk(1, 16'h0009, 0, 0, 0, 1, 0, 5, 0, 0, 6));
        // Full push+pop, then drain everything
        vecs.push_back(mk(1, 16'hBEEF, 1, 0, 0, 1, 1, 6, 0, 0, 6));
        for (int i = 6; i >= 1; i--)
            vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 1, i, 0, 0, 6));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 6));
        // Empty push+pop: no bypass, underflow raised
        vecs.push_back(mk(1, 16'h00AA, 1, 0, 0, 1, 0, 0, 0, 0, 6));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 1, 6));
        for (int i = 1; i <= 5; i++)
            vecs.push_back(mk(1, 16'(16'h0100 + i), 0, 0, 0, 1, 0, i, 0, 1, 6));
        // Overflow set, stat_clr with a coincident reject, then stat_clr alone
        vecs.push_back(mk(1, 16'hDEAD, 0, 0, 0, 0, 0, 6, 0, 1, 6));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 6, 1, 1, 6));
        vecs.push_back(mk(1, 16'h1111, 0, 0, 1, 0, 0, 6, 1, 1, 6));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 0, 6, 1, 0, 6));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 6, 0, 0, 6));
        // Flush at count 4 with push and pop both requested
        vecs.push_back(mk(1, 16'h2222, 0, 0, 0, 0, 0, 6, 0, 0, 6));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 1, 6, 1, 0, 6));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 1, 5, 1, 0, 6));
        vecs.push_back(mk(1, 16'h3333, 1, 1, 0, 0, 0, 4, 1, 0, 6));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 6));
        vecs.push_back(mk(1, 16'h4444, 0, 0, 0, 1, 0, 0, 0, 0, 6));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 1, 1, 0, 0, 6));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 6));
        // Load three words before the mid-operation reset
        vecs.push_back(mk(1, 16'h0A01, 0, 0, 0, 1, 0, 0, 0, 0, 6));
        vecs.push_back(mk(1, 16'h0A02, 0, 0, 0, 1, 0, 1, 0, 0, 6));
        vecs.push_back(mk(1, 16'h0A03, 0, 0, 0, 1, 0, 2, 0, 0, 6));
        // After reset release: watermark restarts at 0
        vecs2.push_back(mk(1, 16'h0B01, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs2.push_back(mk(1, 16'h0B02, 0, 0, 0, 1, 0, 1, 0, 0, 1));
        vecs2.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 1, 2, 0, 0, 2));
        vecs2.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 1, 1, 0, 0, 2));
        vecs2.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 2));

        // Reset state before any clock edge
        #2;
        chk("reset pop_data", 32'(pop_data), 32'h0);
        chk("reset push_ok",  32'(push_ok),  32'h0);
        chk("reset pop_ok",   32'(pop_ok),   32'h0);
        chk("reset max",      32'(max_count), 32'h0);
        chk("reset ovf",      32'(overflow), 32'h0);
        chk("reset udf",      32'(underflow), 32'h0);
        chk_flags("reset", 0);
        @(negedge i_clk);
        i_rstn = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("v%0d", i));

        // Asynchronous reset between edges at count 3
        @(negedge i_clk);
        push = 1'b0; pop = 1'b0; flush = 1'b0; stat_clr = 1'b0;
        #1;
        chk("pre-rst count",    32'(count),    32'd3);
        chk("pre-rst pop_data", 32'(pop_data), 32'h0A01);
        #1;
        i_rstn = 1'b0;
        #1;
        chk("async pop_data", 32'(pop_data),  32'h0);
        chk("async max",      32'(max_count), 32'h0);
        chk("async ovf",      32'(overflow),  32'h0);
        chk_flags("async", 0);
        sb.delete();
        @(negedge i_clk);
        i_rstn = 1'b1;

        for (int i = 0; i < vecs2.size(); i++)
            apply(vecs2[i], $sformatf("r%0d", i));

        @(negedge i_clk);
        push = 1'b0; pop = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
